// File: rtl/warp_ibuffer_scoreboard_pkg.sv
// Shared constants for the warp instruction buffer / scoreboard slice:
// instruction field positions, flag bits, the unused-register index and err bits.
package warp_ibuffer_scoreboard_pkg;

  localparam int INST_W  = 63;
  localparam int REG_W   = 5;
  localparam int RD_LSB  = 58;
  localparam int RS1_LSB = 53;
  localparam int RS2_LSB = 48;

  localparam int FLAG_BRANCH = 2;
  localparam int FLAG_PRED   = 4;

  localparam logic [REG_W-1:0] REG_NONE = 5'd31;

  localparam int ERR_FULL  = 0;
  localparam int ERR_ISSUE = 1;
  localparam int ERR_CLR   = 2;
  localparam int ERR_BEAT  = 3;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_BURST = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/warp_ibuffer_scoreboard_if.sv
// Front-end bundle between fetch/decode, scheduler, writeback and the buffer.
// slave = the instruction buffer, master = the surrounding pipeline.
interface warp_ibuffer_scoreboard_if #(
  parameter int NUM_WARPS = 32,
  parameter int WID_W     = $clog2(NUM_WARPS)
);
  import warp_ibuffer_scoreboard_pkg::*;

  logic                           fetch_req_valid;
  logic                           fetch_req_ready;
  logic [NUM_WARPS-1:0]           fetch_req_mask;
  logic                           dec_valid;
  logic                           dec_last;
  logic [WID_W-1:0]               dec_warp;
  logic [INST_W-1:0]              dec_inst;
  logic [NUM_WARPS-1:0]           warp_ready_mask;
  logic [NUM_WARPS*INST_W-1:0]    head_inst;
  logic                           issue_valid;
  logic [WID_W-1:0]               issue_warp;
  logic                           wb_valid;
  logic [WID_W-1:0]               wb_warp;
  logic [REG_W-1:0]               wb_reg;
  logic                           bar_valid;
  logic [WID_W-1:0]               bar_warp;
  logic                           flush_valid;
  logic [WID_W-1:0]               flush_warp;
  logic [3:0]                     err;

  modport slave (
    output fetch_req_valid, fetch_req_mask, warp_ready_mask, head_inst, err,
    input  fetch_req_ready, dec_valid, dec_last, dec_warp, dec_inst,
           issue_valid, issue_warp, wb_valid, wb_warp, wb_reg,
           bar_valid, bar_warp, flush_valid, flush_warp
  );

  modport master (
    input  fetch_req_valid, fetch_req_mask, warp_ready_mask, head_inst, err,
    output fetch_req_ready, dec_valid, dec_last, dec_warp, dec_inst,
           issue_valid, issue_warp, wb_valid, wb_warp, wb_reg,
           bar_valid, bar_warp, flush_valid, flush_warp
  );

endinterface

// File: rtl/warp_ibuffer_scoreboard_ififo.sv
// warp_ififo: one warp's instruction FIFO with push/pop/flush, registered head,
// plus next-cycle count and head register fields for the ready computation.
module warp_ififo
  import warp_ibuffer_scoreboard_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int W     = INST_W,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   count_nxt,
  output logic [W-1:0]       head,
  output logic [3*REG_W-1:0] regs_nxt
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] cnt_q, remain;
  logic [W-1:0]     head_q, head_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    remain     = cnt_q - CNT_W'(pop);
    rd_ptr_nxt = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_nxt = push ? ptr_inc(wr_ptr) : wr_ptr;
    count_nxt  = remain + CNT_W'(push);
    // a push into a FIFO that drains this cycle becomes the head directly
    head_nxt   = (push && remain == '0) ? push_data : mem[rd_ptr_nxt];
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end
    if (count_nxt == '0) head_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      cnt_q  <= count_nxt;
      head_q <= head_nxt;
    end
  end

  assign count    = cnt_q;
  assign head     = head_q;
  assign regs_nxt = head_nxt[RD_LSB+REG_W-1:RS2_LSB];

endmodule

// File: rtl/warp_ibuffer_scoreboard.sv
// Per-warp instruction buffer, fetch-request FSM and GPR/uniform/branch scoreboard.
// Build option KIANA_SB_BYPASS_EN: ready uses next-state scoreboard (one cycle sooner).
//   state    | meaning
//   FS_IDLE  | no request outstanding; latch free-slot mask when any warp has room
//   FS_REQ   | fetch_req_valid held with stable mask until fetch_req_ready
//   FS_BURST | accepting decoder beats until dec_last
module warp_ibuffer_scoreboard
  import warp_ibuffer_scoreboard_pkg::*;
#(
  parameter int NUM_WARPS = 32,
  parameter int IB_DEPTH  = 2,
  parameter int NUM_GPR   = 16,
  parameter int NUM_UNIR  = 8,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input logic clk,
  input logic rst_n,
  warp_ibuffer_scoreboard_if.slave bus
);

  localparam int CNT_W = $clog2(IB_DEPTH) + 1;

  fetch_state_t             fs_q;
  logic                     fetch_valid_q;
  logic [NUM_WARPS-1:0]     fetch_mask_q, free_mask;
  logic [NUM_WARPS-1:0]     push, pop, flush;
  logic [NUM_WARPS-1:0]     ready_q, ready_nxt;
  logic [NUM_WARPS-1:0]     br_q, br_nxt, br_view;
  logic [NUM_GPR-1:0]       sb_gpr_q [NUM_WARPS];
  logic [NUM_GPR-1:0]       sb_gpr_nxt [NUM_WARPS];
  logic [NUM_GPR-1:0]       sb_gpr_view [NUM_WARPS];
  logic [NUM_UNIR-1:0]      sb_unir_q, sb_unir_nxt, sb_unir_view;
  logic [NUM_GPR-1:0]       gset, gclr;
  logic [NUM_UNIR-1:0]      uset, uclr;
  logic [3:0]               err_q, err_nxt;
  logic [CNT_W-1:0]         cnt [NUM_WARPS];
  logic [CNT_W-1:0]         cnt_nxt [NUM_WARPS];
  logic [INST_W-1:0]        head [NUM_WARPS];
  logic [3*REG_W-1:0]       regs_nxt [NUM_WARPS];
  logic                     beat_ok, tgt_full, issue_ok, iss_br;
  logic [REG_W-1:0]         iss_rd;

  function automatic logic [NUM_GPR-1:0] gpr_oh(input logic [REG_W-1:0] r);
    gpr_oh = '0;
    for (int g = 0; g < NUM_GPR; g++)
      if (int'(r) == g && r != REG_NONE) gpr_oh[g] = 1'b1;
  endfunction

  function automatic logic [NUM_UNIR-1:0] unir_oh(input logic [REG_W-1:0] r);
    unir_oh = '0;
    for (int u = 0; u < NUM_UNIR; u++)
      if (int'(r) == NUM_GPR + u && r != REG_NONE) unir_oh[u] = 1'b1;
  endfunction

  function automatic logic [NUM_GPR-1:0] gpr_uses(input logic [3*REG_W-1:0] f);
    return gpr_oh(f[2*REG_W +: REG_W]) | gpr_oh(f[REG_W +: REG_W]) | gpr_oh(f[0 +: REG_W]);
  endfunction

  function automatic logic [NUM_UNIR-1:0] unir_uses(input logic [3*REG_W-1:0] f);
    return unir_oh(f[2*REG_W +: REG_W]) | unir_oh(f[REG_W +: REG_W]) | unir_oh(f[0 +: REG_W]);
  endfunction

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_fifo
    warp_ififo #(.DEPTH(IB_DEPTH), .W(INST_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[w]),
      .push_data (bus.dec_inst),
      .pop       (pop[w]),
      .flush     (flush[w]),
      .count     (cnt[w]),
      .count_nxt (cnt_nxt[w]),
      .head      (head[w]),
      .regs_nxt  (regs_nxt[w])
    );
    assign bus.head_inst[w*INST_W +: INST_W] = head[w];
    assign free_mask[w] = cnt[w] < CNT_W'(IB_DEPTH);
  end

  always_comb begin
    beat_ok  = bus.dec_valid && (fs_q == FS_BURST);
    tgt_full = cnt[bus.dec_warp] == CNT_W'(IB_DEPTH);
    issue_ok = bus.issue_valid && ready_q[bus.issue_warp];
    iss_rd   = head[bus.issue_warp][RD_LSB +: REG_W];
    iss_br   = head[bus.issue_warp][FLAG_BRANCH] | head[bus.issue_warp][FLAG_PRED];
    push  = '0;
    pop   = '0;
    flush = '0;
    if (beat_ok && !tgt_full && !(bus.flush_valid && bus.flush_warp == bus.dec_warp))
      push[bus.dec_warp] = 1'b1;
    if (issue_ok) pop[bus.issue_warp] = 1'b1;
    if (bus.flush_valid) flush[bus.flush_warp] = 1'b1;

    gset = issue_ok     ? gpr_oh(iss_rd)      : '0;
    uset = issue_ok     ? unir_oh(iss_rd)     : '0;
    gclr = bus.wb_valid ? gpr_oh(bus.wb_reg)  : '0;
    uclr = bus.wb_valid ? unir_oh(bus.wb_reg) : '0;

    // clears are applied before sets so an issue and a writeback on the same bit keep it set
    for (int w = 0; w < NUM_WARPS; w++) sb_gpr_nxt[w] = sb_gpr_q[w];
    sb_gpr_nxt[bus.wb_warp]    = sb_gpr_nxt[bus.wb_warp] & ~gclr;
    sb_gpr_nxt[bus.issue_warp] = sb_gpr_nxt[bus.issue_warp] | gset;
    sb_unir_nxt = (sb_unir_q & ~uclr) | uset;
    br_nxt = br_q;
    if (bus.bar_valid) br_nxt[bus.bar_warp] = 1'b0;
    if (issue_ok && iss_br) br_nxt[bus.issue_warp] = 1'b1;

    err_nxt = '0;
    err_nxt[ERR_FULL]  = beat_ok && tgt_full;
    err_nxt[ERR_ISSUE] = bus.issue_valid && !ready_q[bus.issue_warp];
    err_nxt[ERR_CLR]   = bus.wb_valid && (((gclr & ~sb_gpr_q[bus.wb_warp]) != '0) ||
                                          ((uclr & ~sb_unir_q) != '0));
    err_nxt[ERR_BEAT]  = bus.dec_valid && (fs_q != FS_BURST);
  end

  always_comb begin
`ifdef KIANA_SB_BYPASS_EN
    sb_gpr_view  = sb_gpr_nxt;
    sb_unir_view = sb_unir_nxt;
    br_view      = br_nxt;
`else
    // clears wait for the registered state; new pending bits from issue never may
    for (int w = 0; w < NUM_WARPS; w++) sb_gpr_view[w] = sb_gpr_q[w];
    sb_gpr_view[bus.issue_warp] = sb_gpr_q[bus.issue_warp] | gset;
    sb_unir_view = sb_unir_q | uset;
    br_view = br_q;
    if (issue_ok && iss_br) br_view[bus.issue_warp] = 1'b1;
`endif
    for (int w = 0; w < NUM_WARPS; w++)
      ready_nxt[w] = (cnt_nxt[w] != '0) && !br_view[w] &&
                     ((sb_gpr_view[w] & gpr_uses(regs_nxt[w])) == '0) &&
                     ((sb_unir_view & unir_uses(regs_nxt[w])) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) sb_gpr_q[w] <= '0;
      sb_unir_q <= '0;
      br_q      <= '0;
      ready_q   <= '0;
      err_q     <= '0;
    end else begin
      sb_gpr_q  <= sb_gpr_nxt;
      sb_unir_q <= sb_unir_nxt;
      br_q      <= br_nxt;
      ready_q   <= ready_nxt;
      err_q     <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q          <= FS_IDLE;
      fetch_valid_q <= 1'b0;
      fetch_mask_q  <= '0;
    end else begin
      case (fs_q)
        FS_IDLE: if (|free_mask) begin
          fs_q          <= FS_REQ;
          fetch_valid_q <= 1'b1;
          fetch_mask_q  <= free_mask;
        end
        FS_REQ: if (bus.fetch_req_ready) begin
          fs_q          <= FS_BURST;
          fetch_valid_q <= 1'b0;
          fetch_mask_q  <= '0;
        end
        FS_BURST: if (bus.dec_valid && bus.dec_last) fs_q <= FS_IDLE;
        default: begin
          fs_q          <= FS_IDLE;
          fetch_valid_q <= 1'b0;
          fetch_mask_q  <= '0;
        end
      endcase
    end
  end

  assign bus.fetch_req_valid = fetch_valid_q;
  assign bus.fetch_req_mask  = fetch_mask_q;
  assign bus.warp_ready_mask = ready_q;
  assign bus.err             = err_q;

endmodule

// File: tb/tb_warp_ibuffer_scoreboard.sv
// Directed bench for warp_ibuffer_scoreboard: fetch handshake, hazards, branch
// pending, overflow, flush and error pulses against hand-computed values.
module tb_warp_ibuffer_scoreboard;
  import warp_ibuffer_scoreboard_pkg::*;

  localparam int NW = 32;
  localparam logic [4:0] N = 5'd31;
`ifdef KIANA_SB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  warp_ibuffer_scoreboard_if #(.NUM_WARPS(NW), .WID_W(5)) bus ();

  warp_ibuffer_scoreboard #(
    .NUM_WARPS(NW), .IB_DEPTH(2), .NUM_GPR(16), .NUM_UNIR(8), .WID_W(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [62:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [7:0] flags,
                                     input logic [7:0] opc);
    return {rd, rs1, rs2, opc, 32'hC0DE_0000 | 32'(opc), flags};
  endfunction

  function automatic logic [62:0] head_of(input int w);
    return bus.head_inst[w*63 +: 63];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grant();
    for (int k = 0; k < 20 && !bus.fetch_req_valid; k++) step();
    check("req_wait", 64'(bus.fetch_req_valid), 64'd1);
    bus.fetch_req_ready = 1'b1;
    step();
    bus.fetch_req_ready = 1'b0;
  endtask

  task automatic beat(input logic [4:0] w, input logic [62:0] inst, input logic last);
    bus.dec_valid = 1'b1;
    bus.dec_warp  = w;
    bus.dec_inst  = inst;
    bus.dec_last  = last;
    step();
    bus.dec_valid = 1'b0;
    bus.dec_last  = 1'b0;
  endtask

  task automatic issue(input logic [4:0] w);
    bus.issue_valid = 1'b1;
    bus.issue_warp  = w;
    step();
    bus.issue_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] w, input logic [4:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_warp  = w;
    bus.wb_reg   = r;
    step();
    bus.wb_valid = 1'b0;
  endtask

  logic [62:0] i3a, i3b, i0a, i0b, i2, i7, i4a, i4b, i1a, i1b, i1c, i6a, i6b;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i3a = mk(5'd9, N, N, 8'h00, 8'h30);
    i3b = mk(N, 5'd9, N, 8'h00, 8'h31);
    i0a = mk(5'd5, N, N, 8'h00, 8'h01);
    i0b = mk(N, 5'd5, N, 8'h00, 8'h02);
    i2  = mk(5'd17, N, N, 8'h00, 8'h20);
    i7  = mk(N, N, 5'd17, 8'h00, 8'h70);
    i4a = mk(N, N, N, 8'h04, 8'h40);
    i4b = mk(N, N, N, 8'h00, 8'h41);
    i1a = mk(N, N, N, 8'h00, 8'h10);
    i1b = mk(N, N, N, 8'h00, 8'h11);
    i1c = mk(N, N, N, 8'h00, 8'h12);
    i6a = mk(N, N, N, 8'h00, 8'h60);
    i6b = mk(N, N, N, 8'h00, 8'h61);

    bus.fetch_req_ready = 1'b0;
    bus.dec_valid = 1'b0;  bus.dec_last = 1'b0;  bus.dec_warp = '0;  bus.dec_inst = '0;
    bus.issue_valid = 1'b0; bus.issue_warp = '0;
    bus.wb_valid = 1'b0;   bus.wb_warp = '0;    bus.wb_reg = '0;
    bus.bar_valid = 1'b0;  bus.bar_warp = '0;
    bus.flush_valid = 1'b0; bus.flush_warp = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_fetch_valid", 64'(bus.fetch_req_valid), 64'd0);
    check("rst_fetch_mask", 64'(bus.fetch_req_mask), 64'd0);
    check("rst_ready", 64'(bus.warp_ready_mask), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_head", 64'(|bus.head_inst), 64'd0);

    rst_n = 1'b1;
    step();
    check("req_after_rst", 64'(bus.fetch_req_valid), 64'd1);
    check("mask_after_rst", 64'(bus.fetch_req_mask), 64'hFFFF_FFFF);

    // burst 1: two beats to warp 3
    grant();
    beat(5'd3, i3a, 1'b0);
    beat(5'd3, i3b, 1'b1);
    check("b1_idle_valid", 64'(bus.fetch_req_valid), 64'd0);
    check("b1_head3", 64'(head_of(3)), 64'(i3a));
    check("b1_ready3", 64'(bus.warp_ready_mask[3]), 64'd1);
    step();
    check("b1_mask", 64'(bus.fetch_req_mask), 64'hFFFF_FFF7);

    // burst 2: hazard setups, overflow of warp 1, flush of warp 6 with push
    grant();
    beat(5'd0, i0a, 1'b0);
    beat(5'd0, i0b, 1'b0);
    beat(5'd2, i2,  1'b0);
    beat(5'd7, i7,  1'b0);
    beat(5'd4, i4a, 1'b0);
    beat(5'd4, i4b, 1'b0);
    beat(5'd1, i1a, 1'b0);
    beat(5'd1, i1b, 1'b0);
    beat(5'd1, i1c, 1'b0);
    check("err_full", 64'(bus.err), 64'h1);
    beat(5'd6, i6a, 1'b0);
    check("err_full_pulse", 64'(bus.err), 64'h0);
    bus.flush_valid = 1'b1;
    bus.flush_warp  = 5'd6;
    beat(5'd6, i6b, 1'b1);
    bus.flush_valid = 1'b0;
    check("b2_ready", 64'(bus.warp_ready_mask), 64'h9F);
    check("flush_head6", 64'(head_of(6)), 64'd0);
    check("full_head1", 64'(head_of(1)), 64'(i1a));
    check("flush_err", 64'(bus.err), 64'h0);
    step();
    check("b2_mask", 64'(bus.fetch_req_mask), 64'hFFFF_FFE4);

    // GPR hazard on warp 0
    issue(5'd0);
    check("raw_ready0", 64'(bus.warp_ready_mask[0]), 64'd0);
    check("raw_head0", 64'(head_of(0)), 64'(i0b));
    wb(5'd0, 5'd5);
    check("wb_ready0_n1", 64'(bus.warp_ready_mask[0]), 64'(BYP));
    check("wb_err0", 64'(bus.err), 64'h0);
    step();
    check("wb_ready0_n2", 64'(bus.warp_ready_mask[0]), 64'd1);

    // shared uniform register 17 between warps 2 and 7
    issue(5'd2);
    check("unir_ready7", 64'(bus.warp_ready_mask[7]), 64'd0);
    check("empty_ready2", 64'(bus.warp_ready_mask[2]), 64'd0);
    wb(5'd5, 5'd17);
    check("unir_ready7_n1", 64'(bus.warp_ready_mask[7]), 64'(BYP));
    step();
    check("unir_ready7_n2", 64'(bus.warp_ready_mask[7]), 64'd1);

    // branch pending on warp 4, then a rejected issue
    issue(5'd4);
    check("br_ready4", 64'(bus.warp_ready_mask[4]), 64'd0);
    check("br_head4", 64'(head_of(4)), 64'(i4b));
    issue(5'd4);
    check("err_issue", 64'(bus.err), 64'h2);
    check("noissue_head4", 64'(head_of(4)), 64'(i4b));
    bus.bar_valid = 1'b1;
    bus.bar_warp  = 5'd4;
    step();
    bus.bar_valid = 1'b0;
    check("bar_ready4_n1", 64'(bus.warp_ready_mask[4]), 64'(BYP));
    check("err_issue_pulse", 64'(bus.err), 64'h0);
    step();
    check("bar_ready4_n2", 64'(bus.warp_ready_mask[4]), 64'd1);

    // clear of an unset bit, and a beat outside a burst
    wb(5'd9, 5'd3);
    check("err_clr", 64'(bus.err), 64'h4);
    step();
    check("err_clr_pulse", 64'(bus.err), 64'h0);
    beat(5'd9, i1a, 1'b0);
    check("err_beat", 64'(bus.err), 64'h8);
    check("beat_drop9", 64'(bus.warp_ready_mask[9]), 64'd0);

    // same-cycle set by issue and clear by writeback on warp 3 reg 9
    bus.wb_valid = 1'b1;
    bus.wb_warp  = 5'd3;
    bus.wb_reg   = 5'd9;
    issue(5'd3);
    bus.wb_valid = 1'b0;
    check("setwin_err", 64'(bus.err), 64'h4);
    check("setwin_ready3_n1", 64'(bus.warp_ready_mask[3]), 64'd0);
    step();
    check("setwin_ready3_n2", 64'(bus.warp_ready_mask[3]), 64'd0);
    wb(5'd3, 5'd9);
    check("wb_ready3_n1", 64'(bus.warp_ready_mask[3]), 64'(BYP));
    step();
    check("wb_ready3_n2", 64'(bus.warp_ready_mask[3]), 64'd1);
    check("final_ready", 64'(bus.warp_ready_mask), 64'h9B);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
